// File: rtl/ex_stage.sv
// RV32I execute stage: ID/EX register, operand select with distance-1 forwarding, ALU, EX/MEM register.
// Optional performance counters are built only when EX_PERF_CNT_EN is defined.

module alu #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALUOp,
   output logic [WIDTH-1:0] ALURes
);

   localparam int SHW = $clog2(WIDTH);

   logic [SHW-1:0] w_shamt;
   logic           w_lt_s;
   logic           w_lt_u;

   assign w_shamt = B[SHW-1:0];
   assign w_lt_s  = $signed(A) < $signed(B);
   assign w_lt_u  = A < B;

   always_comb begin
      ALURes = '0;
      case (ALUOp)
         4'b0000: ALURes = A + B;
         4'b1000: ALURes = A - B;
         4'b0001: ALURes = A << w_shamt;
         4'b0010: ALURes = {{(WIDTH-1){1'b0}}, w_lt_s};
         4'b0011: ALURes = {{(WIDTH-1){1'b0}}, w_lt_u};
         4'b0100: ALURes = A ^ B;
         4'b0101: ALURes = A >> w_shamt;
         4'b1101: ALURes = $unsigned($signed(A) >>> w_shamt);
         4'b0110: ALURes = A | B;
         4'b0111: ALURes = A & B;
         default: ALURes = '0;
      endcase
   end

endmodule

module ex_stage #(
   parameter int WIDTH = 32,
   parameter int RADDR = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_pc,
   input  logic [WIDTH-1:0] in_rs1_data,
   input  logic [WIDTH-1:0] in_rs2_data,
   input  logic [RADDR-1:0] in_rs1_addr,
   input  logic [RADDR-1:0] in_rs2_addr,
   input  logic [WIDTH-1:0] in_imm,
   input  logic [3:0]       in_alu_op,
   input  logic [1:0]       in_a_sel,
   input  logic             in_b_sel,
   input  logic [RADDR-1:0] in_rd,
   input  logic             in_reg_write,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_alu_res,
   output logic [WIDTH-1:0] out_store_data,
   output logic [RADDR-1:0] out_rd,
   output logic             out_reg_write,
   output logic [31:0]      perf_issued,
   output logic [31:0]      perf_stall,
   output logic [31:0]      perf_fwd
);

   // ID/EX register
   logic             r_s1_valid;
   logic [WIDTH-1:0] r_s1_pc;
   logic [WIDTH-1:0] r_s1_rs1_data;
   logic [WIDTH-1:0] r_s1_rs2_data;
   logic [RADDR-1:0] r_s1_rs1_addr;
   logic [RADDR-1:0] r_s1_rs2_addr;
   logic [WIDTH-1:0] r_s1_imm;
   logic [3:0]       r_s1_alu_op;
   logic [1:0]       r_s1_a_sel;
   logic             r_s1_b_sel;
   logic [RADDR-1:0] r_s1_rd;
   logic             r_s1_reg_write;

   // EX/MEM register
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_alu_res;
   logic [WIDTH-1:0] r_out_store_data;
   logic [RADDR-1:0] r_out_rd;
   logic             r_out_reg_write;

   logic             w_s2_free;
   logic             w_in_ready;
   logic             w_accept;
   logic             w_advance;
   logic             w_fwd1;
   logic             w_fwd2;
   logic [WIDTH-1:0] w_rs1_val;
   logic [WIDTH-1:0] w_rs2_val;
   logic [WIDTH-1:0] w_alu_a;
   logic [WIDTH-1:0] w_alu_b;
   logic [WIDTH-1:0] w_alu_res;

   assign w_s2_free  = !r_out_valid | out_ready;
   assign w_in_ready = !r_s1_valid | w_s2_free;
   assign w_accept   = in_valid & w_in_ready;
   assign w_advance  = r_s1_valid & w_s2_free;

   // Only the instruction sitting in EX/MEM is forwarded; older results come from the register file.
   assign w_fwd1 = r_out_valid & r_out_reg_write & (r_out_rd != '0) & (r_out_rd == r_s1_rs1_addr);
   assign w_fwd2 = r_out_valid & r_out_reg_write & (r_out_rd != '0) & (r_out_rd == r_s1_rs2_addr);

   assign w_rs1_val = w_fwd1 ? r_out_alu_res : r_s1_rs1_data;
   assign w_rs2_val = w_fwd2 ? r_out_alu_res : r_s1_rs2_data;

   always_comb begin
      w_alu_a = w_rs1_val;
      case (r_s1_a_sel)
         2'b01:   w_alu_a = r_s1_pc;
         2'b10:   w_alu_a = '0;
         default: w_alu_a = w_rs1_val;
      endcase
   end

   assign w_alu_b = r_s1_b_sel ? r_s1_imm : w_rs2_val;

   alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .A      (w_alu_a),
      .B      (w_alu_b),
      .ALUOp  (r_s1_alu_op),
      .ALURes (w_alu_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid     <= 1'b0;
         r_s1_pc        <= '0;
         r_s1_rs1_data  <= '0;
         r_s1_rs2_data  <= '0;
         r_s1_rs1_addr  <= '0;
         r_s1_rs2_addr  <= '0;
         r_s1_imm       <= '0;
         r_s1_alu_op    <= '0;
         r_s1_a_sel     <= '0;
         r_s1_b_sel     <= 1'b0;
         r_s1_rd        <= '0;
         r_s1_reg_write <= 1'b0;
      end else if (flush) begin
         r_s1_valid <= 1'b0;
      end else if (w_in_ready) begin
         // in_ready means S1 is empty or draining this cycle, so it simply takes whatever arrives
         r_s1_valid <= in_valid;
         if (w_accept) begin
            r_s1_pc        <= in_pc;
            r_s1_rs1_data  <= in_rs1_data;
            r_s1_rs2_data  <= in_rs2_data;
            r_s1_rs1_addr  <= in_rs1_addr;
            r_s1_rs2_addr  <= in_rs2_addr;
            r_s1_imm       <= in_imm;
            r_s1_alu_op    <= in_alu_op;
            r_s1_a_sel     <= in_a_sel;
            r_s1_b_sel     <= in_b_sel;
            r_s1_rd        <= in_rd;
            r_s1_reg_write <= in_reg_write;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid      <= 1'b0;
         r_out_alu_res    <= '0;
         r_out_store_data <= '0;
         r_out_rd         <= '0;
         r_out_reg_write  <= 1'b0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_s2_free) begin
         r_out_valid <= r_s1_valid;
         if (w_advance) begin
            r_out_alu_res    <= w_alu_res;
            r_out_store_data <= w_rs2_val;
            r_out_rd         <= r_s1_rd;
            r_out_reg_write  <= r_s1_reg_write;
         end
      end
   end

   assign in_ready       = w_in_ready;
   assign out_valid      = r_out_valid;
   assign out_alu_res    = r_out_alu_res;
   assign out_store_data = r_out_store_data;
   assign out_rd         = r_out_rd;
   assign out_reg_write  = r_out_reg_write;

`ifdef EX_PERF_CNT_EN
   logic [31:0] r_perf_issued;
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_fwd;

   // Counters survive flush; only reset clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_issued <= '0;
         r_perf_stall  <= '0;
         r_perf_fwd    <= '0;
      end else begin
         if (r_out_valid & out_ready)
            r_perf_issued <= r_perf_issued + 32'd1;
         if (r_out_valid & !out_ready)
            r_perf_stall <= r_perf_stall + 32'd1;
         if (!flush & w_advance & (w_fwd1 | w_fwd2))
            r_perf_fwd <= r_perf_fwd + 32'd1;
      end
   end

   assign perf_issued = r_perf_issued;
   assign perf_stall  = r_perf_stall;
   assign perf_fwd    = r_perf_fwd;
`else
   assign perf_issued = 32'd0;
   assign perf_stall  = 32'd0;
   assign perf_fwd    = 32'd0;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: scoreboard queue filled on accept, drained when a result leaves the stage.

module tb_ex_stage;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b0001;
   localparam logic [3:0] OP_SLT  = 4'b0010;
   localparam logic [3:0] OP_SLTU = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SRA  = 4'b1101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b0111;

`ifdef EX_PERF_CNT_EN
   localparam bit PERF_EN = 1'b1;
`else
   localparam bit PERF_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] res;
      logic [31:0] st;
      logic [4:0]  rd;
      logic        rw;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_rs1_data;
   logic [31:0] in_rs2_data;
   logic [4:0]  in_rs1_addr;
   logic [4:0]  in_rs2_addr;
   logic [31:0] in_imm;
   logic [3:0]  in_alu_op;
   logic [1:0]  in_a_sel;
   logic        in_b_sel;
   logic [4:0]  in_rd;
   logic        in_reg_write;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_alu_res;
   logic [31:0] out_store_data;
   logic [4:0]  out_rd;
   logic        out_reg_write;
   logic [31:0] perf_issued;
   logic [31:0] perf_stall;
   logic [31:0] perf_fwd;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_pop = 0;

   ex_stage #(.WIDTH(32), .RADDR(5)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush          (flush),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_pc          (in_pc),
      .in_rs1_data    (in_rs1_data),
      .in_rs2_data    (in_rs2_data),
      .in_rs1_addr    (in_rs1_addr),
      .in_rs2_addr    (in_rs2_addr),
      .in_imm         (in_imm),
      .in_alu_op      (in_alu_op),
      .in_a_sel       (in_a_sel),
      .in_b_sel       (in_b_sel),
      .in_rd          (in_rd),
      .in_reg_write   (in_reg_write),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_alu_res    (out_alu_res),
      .out_store_data (out_store_data),
      .out_rd         (out_rd),
      .out_reg_write  (out_reg_write),
      .perf_issued    (perf_issued),
      .perf_stall     (perf_stall),
      .perf_fwd       (perf_fwd)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      step(n);
   endtask

   // Drives one instruction, waits (bounded) for in_ready, records the expectation, then clocks it in.
   task automatic issue(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] ra, input logic [4:0] rb, input logic [31:0] imm,
                        input logic [3:0] op, input logic [1:0] asel, input logic bsel,
                        input logic [4:0] rd, input logic rw,
                        input logic [31:0] eres, input logic [31:0] est);
      exp_t e;
      int   guard;
      in_valid     = 1'b1;
      in_pc        = pc;
      in_rs1_data  = a;
      in_rs2_data  = b;
      in_rs1_addr  = ra;
      in_rs2_addr  = rb;
      in_imm       = imm;
      in_alu_op    = op;
      in_a_sel     = asel;
      in_b_sel     = bsel;
      in_rd        = rd;
      in_reg_write = rw;
      guard = 0;
      while (!in_ready && guard < 20) begin
         step(1);
         guard++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL issue_timeout: in_ready observed 0 required 1 within 20 cycles");
      end
      e.res = eres;
      e.st  = est;
      e.rd  = rd;
      e.rw  = rw;
      sb_q.push_back(e);
      step(1);
   endtask

   // Outputs are sampled on the falling edge; inputs only change just after rising edges.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_output: out_alu_res observed %h required no transfer", out_alu_res);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            n_pop++;
            check("out_alu_res", out_alu_res, e.res);
            check("out_store_data", out_store_data, e.st);
            check("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
            check("out_reg_write", {31'd0, out_reg_write}, {31'd0, e.rw});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time observed 200000 required completion earlier");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n        = 1'b0;
      flush        = 1'b0;
      in_valid     = 1'b0;
      in_pc        = '0;
      in_rs1_data  = '0;
      in_rs2_data  = '0;
      in_rs1_addr  = '0;
      in_rs2_addr  = '0;
      in_imm       = '0;
      in_alu_op    = '0;
      in_a_sel     = '0;
      in_b_sel     = 1'b0;
      in_rd        = '0;
      in_reg_write = 1'b0;
      out_ready    = 1'b1;
      step(2);

      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_alu_res", out_alu_res, 32'd0);
      check("rst_out_store_data", out_store_data, 32'd0);
      check("rst_out_rd", {27'd0, out_rd}, 32'd0);
      check("rst_out_reg_write", {31'd0, out_reg_write}, 32'd0);
      check("rst_perf_issued", perf_issued, 32'd0);
      check("rst_perf_stall", perf_stall, 32'd0);
      check("rst_perf_fwd", perf_fwd, 32'd0);
      rst_n = 1'b1;
      step(1);

      // ADDI x5 = 10 + 5, then ADD x6 = x5 + x5 with stale register data
      issue(32'h0, 32'd10, 32'd0, 5'd1, 5'd0, 32'd5, OP_ADD, 2'b00, 1'b1, 5'd5, 1'b1, 32'd15, 32'd0);
      issue(32'h4, 32'd0, 32'd0, 5'd5, 5'd5, 32'd0, OP_ADD, 2'b00, 1'b0, 5'd6, 1'b1, 32'd30, 32'd15);
      check("lat_i1_valid", {31'd0, out_valid}, 32'd1);
      check("lat_i1_res", out_alu_res, 32'd15);
      idle(1);
      check("lat_i2_res", out_alu_res, 32'd30);
      check("fwd_store", out_store_data, 32'd15);
      check("perf_fwd_after_dep", perf_fwd, PERF_EN ? 32'd1 : 32'd0);
      idle(2);

      // Backpressure: SUB then XOR, downstream stalls three cycles
      issue(32'h8, 32'd10, 32'd5, 5'd2, 5'd3, 32'd0, OP_SUB, 2'b00, 1'b0, 5'd7, 1'b1, 32'd5, 32'd5);
      issue(32'hC, 32'hDEADBEEF, 32'h12345678, 5'd4, 5'd9, 32'd0, OP_XOR, 2'b00, 1'b0, 5'd8, 1'b1,
            32'hCC99E897, 32'h12345678);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("bp_hold_res", out_alu_res, 32'd5);
         check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      step(2);
      check("bp_perf_stall", perf_stall, PERF_EN ? 32'd3 : 32'd0);
      idle(1);

      // ALU coverage, back-to-back with independent registers
      issue(32'h10, 32'hFFFFFFF8, 32'd0, 5'd10, 5'd0, 32'd2, OP_SRA, 2'b00, 1'b1, 5'd9, 1'b1,
            32'hFFFFFFFE, 32'd0);
      issue(32'h14, 32'hFFFFFFFB, 32'd5, 5'd11, 5'd12, 32'd0, OP_SLT, 2'b00, 1'b0, 5'd13, 1'b1,
            32'd1, 32'd5);
      issue(32'h18, 32'hFFFFFFFB, 32'd5, 5'd14, 5'd15, 32'd0, OP_SLTU, 2'b00, 1'b0, 5'd16, 1'b1,
            32'd0, 32'd5);
      issue(32'h1C, 32'd1, 32'd0, 5'd17, 5'd0, 32'd31, OP_SLL, 2'b00, 1'b1, 5'd18, 1'b1,
            32'h80000000, 32'd0);
      issue(32'h20, 32'h80000000, 32'd4, 5'd19, 5'd23, 32'd0, OP_SRL, 2'b00, 1'b0, 5'd24, 1'b1,
            32'h08000000, 32'd4);
      issue(32'h24, 32'hF0F00000, 32'h0000F0F0, 5'd25, 5'd26, 32'd0, OP_OR, 2'b00, 1'b0, 5'd27, 1'b0,
            32'hF0F0F0F0, 32'h0000F0F0);
      issue(32'h28, 32'hFF00FF00, 32'h0FF00FF0, 5'd28, 5'd29, 32'd0, OP_AND, 2'b00, 1'b0, 5'd30, 1'b1,
            32'h0F000F00, 32'h0FF00FF0);
      idle(3);

      // Flush with both stages full
      out_ready = 1'b0;
      issue(32'h30, 32'd1, 32'd1, 5'd17, 5'd19, 32'd0, OP_ADD, 2'b00, 1'b0, 5'd20, 1'b1, 32'd2, 32'd1);
      issue(32'h34, 32'd2, 32'd2, 5'd25, 5'd26, 32'd0, OP_ADD, 2'b00, 1'b0, 5'd21, 1'b1, 32'd4, 32'd2);
      in_valid = 1'b0;
      check("pre_flush_in_ready", {31'd0, in_ready}, 32'd0);
      check("pre_flush_valid", {31'd0, out_valid}, 32'd1);
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      sb_q.delete();
      check("flush_out_valid", {31'd0, out_valid}, 32'd0);
      check("flush_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      issue(32'h100, 32'd0, 32'd0, 5'd0, 5'd0, 32'h1000, OP_ADD, 2'b01, 1'b1, 5'd22, 1'b1,
            32'h1100, 32'd0);
      in_valid = 1'b0;
      check("auipc_no_stale", {31'd0, out_valid}, 32'd0);
      step(1);
      check("auipc_valid", {31'd0, out_valid}, 32'd1);
      check("auipc_res", out_alu_res, 32'h1100);
      idle(2);

      // x0 is never forwarded even though reg_write is passed through
      issue(32'h40, 32'd7, 32'd0, 5'd2, 5'd0, 32'd0, OP_ADD, 2'b00, 1'b1, 5'd0, 1'b1, 32'd7, 32'd0);
      issue(32'h44, 32'd0, 32'd0, 5'd0, 5'd0, 32'd3, OP_ADD, 2'b00, 1'b1, 5'd1, 1'b1, 32'd3, 32'd0);
      idle(3);

      check("sb_drained", sb_q.size(), 32'd0);
      check("perf_issued_total", perf_issued, PERF_EN ? n_pop : 32'd0);
      check("perf_stall_total", perf_stall, PERF_EN ? 32'd4 : 32'd0);
      check("perf_fwd_total", perf_fwd, PERF_EN ? 32'd1 : 32'd0);

      // Asynchronous reset while a result is waiting downstream
      out_ready = 1'b0;
      issue(32'h50, 32'd9, 32'd0, 5'd3, 5'd0, 32'd1, OP_ADD, 2'b00, 1'b1, 5'd4, 1'b1, 32'd10, 32'd0);
      in_valid = 1'b0;
      step(1);
      check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", {31'd0, out_valid}, 32'd0);
      check("async_rst_res", out_alu_res, 32'd0);
      check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("async_rst_perf_issued", perf_issued, 32'd0);
      check("async_rst_perf_stall", perf_stall, 32'd0);
      check("async_rst_perf_fwd", perf_fwd, 32'd0);
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("post_rst_quiet", {31'd0, out_valid}, 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
